// File: rtl/bool_comp_monitor.sv
// Stream monitor: HLC latches input events and schedules streams, a 5-stage LLC evaluates them.
// Optional macro BOOL_COMP_DROP_CNT_EN adds a saturating dropped-event counter port.
module bool_comp_monitor #(
    parameter int unsigned PERIOD_CYCLES = 500,
    parameter int          LT_BOUND      = 3,
    parameter int          GT_BOUND      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                input_a,
    input  logic                new_input_a,
    input  logic                input_b,
    input  logic                new_input_b,
    input  logic signed [7:0]   input_id,
    input  logic                new_input_id,
`ifdef BOOL_COMP_DROP_CNT_EN
    output logic [15:0]         dropped_cnt,
`endif
    output logic                hlc_clock,
    output logic signed [63:0]  hlc_clock_cnt,
    output logic                hlc_a,
    output logic                hlc_b,
    output logic signed [7:0]   hlc_id,
    output logic                hlc_en_lt,
    output logic                hlc_en_gt,
    output logic                hlc_en_neq,
    output logic                hlc_en_not_a,
    output logic                hlc_en_a_impl_b,
    output logic                hlc_en_time_stream,
    output logic signed [63:0]  llc_stage,
    output logic                output_lt,
    output logic                output_gt,
    output logic                output_neq,
    output logic                output_not_a,
    output logic                output_a_impl_b,
    output logic signed [7:0]   output_time_stream,
    output logic                output_lt_aktv,
    output logic                output_gt_aktv,
    output logic                output_neq_aktv,
    output logic                output_not_a_aktv,
    output logic                output_a_impl_b_aktv,
    output logic                output_time_stream_aktv
);

    localparam int unsigned PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);

    localparam int unsigned NSTREAM = 6;
    localparam int unsigned IDX_LT  = 0;
    localparam int unsigned IDX_GT  = 1;
    localparam int unsigned IDX_NEQ = 2;
    localparam int unsigned IDX_NA  = 3;
    localparam int unsigned IDX_AIB = 4;
    localparam int unsigned IDX_TS  = 5;

    localparam logic [2:0] ST_S0 = 3'd0;
    localparam logic [2:0] ST_S1 = 3'd1;
    localparam logic [2:0] ST_S2 = 3'd2;
    localparam logic [2:0] ST_S3 = 3'd3;
    localparam logic [2:0] ST_S4 = 3'd4;

    logic [2:0]          stage_q, stage_d;
    logic [PW-1:0]       period_q, period_d;
    logic                tick_q, tick_d;
    logic                busy_q, busy_d;
    logic                hlc_clock_q, hlc_clock_d;
    logic signed [63:0]  cnt_q, cnt_d;
    logic                a_q, a_d;
    logic                b_q, b_d;
    logic signed [7:0]   id_q, id_d;
    logic [NSTREAM-1:0]  sched_q, sched_d;
    logic [NSTREAM-1:0]  aktv_q, aktv_d;
    logic                lt_q, lt_d;
    logic                gt_q, gt_d;
    logic                neq_q, neq_d;
    logic                not_a_q, not_a_d;
    logic                aib_q, aib_d;
    logic signed [7:0]   ts_q, ts_d;
`ifdef BOOL_COMP_DROP_CNT_EN
    logic [15:0]         drop_q, drop_d;
`endif

    logic any_new;
    logic wrap;
    logic accept;
    logic evaluate;

    // Next-state: stage/period advance, event acceptance and stage-4 evaluation
    always_comb begin
        stage_d     = stage_q;
        period_d    = period_q;
        tick_d      = tick_q;
        busy_d      = busy_q;
        hlc_clock_d = 1'b0;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        sched_d     = sched_q;
        aktv_d      = '0;
        lt_d        = lt_q;
        gt_d        = gt_q;
        neq_d       = neq_q;
        not_a_d     = not_a_q;
        aib_d       = aib_q;
        ts_d        = ts_q;
        wrap        = 1'b0;
        accept      = 1'b0;
        evaluate    = 1'b0;
        any_new     = new_input_a | new_input_b | new_input_id;

        if (en) begin
            case (stage_q)
                ST_S0:   stage_d = ST_S1;
                ST_S1:   stage_d = ST_S2;
                ST_S2:   stage_d = ST_S3;
                ST_S3:   stage_d = ST_S4;
                ST_S4:   stage_d = ST_S0;
                default: stage_d = ST_S0;
            endcase
            wrap     = (period_q == PERIOD_LAST);
            period_d = wrap ? '0 : period_q + PW'(1);
            accept   = (stage_q == ST_S0) && (any_new || tick_q);
            evaluate = (stage_q == ST_S4) && busy_q;
        end

        // A wrap on the consuming edge re-arms the tick; back-to-back wraps collapse
        tick_d = wrap | (tick_q & ~accept);

        if (accept) begin
            if (new_input_a)  a_d  = input_a;
            if (new_input_b)  b_d  = input_b;
            if (new_input_id) id_d = input_id;
            sched_d[IDX_LT]  = new_input_id;
            sched_d[IDX_GT]  = new_input_id;
            sched_d[IDX_NEQ] = new_input_a & new_input_b;
            sched_d[IDX_NA]  = new_input_a;
            sched_d[IDX_AIB] = new_input_a & new_input_b;
            sched_d[IDX_TS]  = tick_q;
            hlc_clock_d      = 1'b1;
            cnt_d            = cnt_q + 64'sd1;
            busy_d           = 1'b1;
        end

        if (evaluate) begin
            busy_d = 1'b0;
            aktv_d = sched_q;
            if (sched_q[IDX_LT])  lt_d    = (int'(id_q) < LT_BOUND);
            if (sched_q[IDX_GT])  gt_d    = (int'(id_q) > GT_BOUND);
            if (sched_q[IDX_NEQ]) neq_d   = a_q ^ b_q;
            if (sched_q[IDX_NA])  not_a_d = ~a_q;
            if (sched_q[IDX_AIB]) aib_d   = ~a_q | b_q;
            if (sched_q[IDX_TS])  ts_d    = ts_q + 8'sd1;
        end
    end

`ifdef BOOL_COMP_DROP_CNT_EN
    // Events arriving while the LLC is busy are counted, saturating
    always_comb begin
        drop_d = drop_q;
        if (en && any_new && (stage_q != ST_S0) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign dropped_cnt = drop_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q     <= ST_S0;
            period_q    <= '0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
            hlc_clock_q <= 1'b0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            id_q        <= '0;
            sched_q     <= '0;
            aktv_q      <= '0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            neq_q       <= 1'b0;
            not_a_q     <= 1'b0;
            aib_q       <= 1'b0;
            ts_q        <= '0;
        end else begin
            stage_q     <= stage_d;
            period_q    <= period_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            hlc_clock_q <= hlc_clock_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            sched_q     <= sched_d;
            aktv_q      <= aktv_d;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            neq_q       <= neq_d;
            not_a_q     <= not_a_d;
            aib_q       <= aib_d;
            ts_q        <= ts_d;
        end
    end

    // Strobes are forced low while the monitor is disabled
    assign hlc_clock               = hlc_clock_q & en;
    assign output_lt_aktv          = aktv_q[IDX_LT]  & en;
    assign output_gt_aktv          = aktv_q[IDX_GT]  & en;
    assign output_neq_aktv         = aktv_q[IDX_NEQ] & en;
    assign output_not_a_aktv       = aktv_q[IDX_NA]  & en;
    assign output_a_impl_b_aktv    = aktv_q[IDX_AIB] & en;
    assign output_time_stream_aktv = aktv_q[IDX_TS]  & en;

    assign hlc_clock_cnt      = cnt_q;
    assign hlc_a              = a_q;
    assign hlc_b              = b_q;
    assign hlc_id             = id_q;
    assign hlc_en_lt          = sched_q[IDX_LT];
    assign hlc_en_gt          = sched_q[IDX_GT];
    assign hlc_en_neq         = sched_q[IDX_NEQ];
    assign hlc_en_not_a       = sched_q[IDX_NA];
    assign hlc_en_a_impl_b    = sched_q[IDX_AIB];
    assign hlc_en_time_stream = sched_q[IDX_TS];
    assign llc_stage          = 64'(stage_q);

    assign output_lt          = lt_q;
    assign output_gt          = gt_q;
    assign output_neq         = neq_q;
    assign output_not_a       = not_a_q;
    assign output_a_impl_b    = aib_q;
    assign output_time_stream = ts_q;

endmodule

// File: tb/tb_bool_comp_monitor.sv
// Testbench for bool_comp_monitor: directed vector table, periodic-stream sequence,
// drop and mid-evaluation reset sequences, plus randomized traffic against a queue-based model.
module tb_bool_comp_monitor;

    localparam int PER = 500;
    localparam int LTB = 3;
    localparam int GTB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic input_a = 1'b0, new_input_a = 1'b0;
    logic input_b = 1'b0, new_input_b = 1'b0;
    logic signed [7:0] input_id = '0;
    logic new_input_id = 1'b0;

    logic hlc_clock;
    logic signed [63:0] hlc_clock_cnt;
    logic hlc_a, hlc_b;
    logic signed [7:0] hlc_id;
    logic hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream;
    logic signed [63:0] llc_stage;
    logic output_lt, output_gt, output_neq, output_not_a, output_a_impl_b;
    logic signed [7:0] output_time_stream;
    logic output_lt_aktv, output_gt_aktv, output_neq_aktv, output_not_a_aktv;
    logic output_a_impl_b_aktv, output_time_stream_aktv;
`ifdef BOOL_COMP_DROP_CNT_EN
    logic [15:0] dropped_cnt;
`endif

    always #5 clk = ~clk;

    bool_comp_monitor #(.PERIOD_CYCLES(PER), .LT_BOUND(LTB), .GT_BOUND(GTB)) dut (
        .clk(clk), .rst(rst), .en(en),
        .input_a(input_a), .new_input_a(new_input_a),
        .input_b(input_b), .new_input_b(new_input_b),
        .input_id(input_id), .new_input_id(new_input_id),
`ifdef BOOL_COMP_DROP_CNT_EN
        .dropped_cnt(dropped_cnt),
`endif
        .hlc_clock(hlc_clock), .hlc_clock_cnt(hlc_clock_cnt),
        .hlc_a(hlc_a), .hlc_b(hlc_b), .hlc_id(hlc_id),
        .hlc_en_lt(hlc_en_lt), .hlc_en_gt(hlc_en_gt), .hlc_en_neq(hlc_en_neq),
        .hlc_en_not_a(hlc_en_not_a), .hlc_en_a_impl_b(hlc_en_a_impl_b),
        .hlc_en_time_stream(hlc_en_time_stream),
        .llc_stage(llc_stage),
        .output_lt(output_lt), .output_gt(output_gt), .output_neq(output_neq),
        .output_not_a(output_not_a), .output_a_impl_b(output_a_impl_b),
        .output_time_stream(output_time_stream),
        .output_lt_aktv(output_lt_aktv), .output_gt_aktv(output_gt_aktv),
        .output_neq_aktv(output_neq_aktv), .output_not_a_aktv(output_not_a_aktv),
        .output_a_impl_b_aktv(output_a_impl_b_aktv),
        .output_time_stream_aktv(output_time_stream_aktv)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int       due;
        bit [5:0] mask;   // [0]lt [1]gt [2]neq [3]not_a [4]a_impl_b [5]time_stream
        bit       lt, gt, neq, not_a, aib;
    } ev_t;

    ev_t     m_q[$];
    ev_t     m_r;
    int      m_en_clks;
    bit      m_tick, m_hlc_clock, m_a, m_b, m_any, m_acc;
    longint  m_cnt;
    byte     m_id, m_ts;
    bit [5:0] m_sched, m_aktv;
    bit      m_lt, m_gt, m_neq, m_not_a, m_aib;
    int      m_drop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_en_clks = 0; m_tick = 0; m_hlc_clock = 0; m_a = 0; m_b = 0;
            m_cnt = 0; m_id = 0; m_ts = 0; m_sched = '0; m_aktv = '0;
            m_lt = 0; m_gt = 0; m_neq = 0; m_not_a = 0; m_aib = 0; m_drop = 0;
        end else begin
            m_hlc_clock = 0;
            m_aktv = '0;
            if (en) begin
                m_any = new_input_a || new_input_b || new_input_id;
                if (m_q.size() > 0 && m_q[0].due == m_en_clks) begin
                    m_r = m_q.pop_front();
                    m_aktv = m_r.mask;
                    if (m_r.mask[0]) m_lt = m_r.lt;
                    if (m_r.mask[1]) m_gt = m_r.gt;
                    if (m_r.mask[2]) m_neq = m_r.neq;
                    if (m_r.mask[3]) m_not_a = m_r.not_a;
                    if (m_r.mask[4]) m_aib = m_r.aib;
                    if (m_r.mask[5]) m_ts = m_ts + 8'sd1;
                end
                m_acc = (m_en_clks % 5 == 0) && (m_any || m_tick);
                if (m_acc) begin
                    if (new_input_a) m_a = input_a;
                    if (new_input_b) m_b = input_b;
                    if (new_input_id) m_id = input_id;
                    m_sched = {m_tick, new_input_a && new_input_b, new_input_a,
                               new_input_a && new_input_b, new_input_id, new_input_id};
                    m_r.due = m_en_clks + 4;
                    m_r.mask = m_sched;
                    m_r.lt = int'(m_id) < LTB;
                    m_r.gt = int'(m_id) > GTB;
                    m_r.neq = m_a != m_b;
                    m_r.not_a = !m_a;
                    m_r.aib = !m_a || m_b;
                    m_q.push_back(m_r);
                    m_hlc_clock = 1;
                    m_cnt++;
                end else if (m_any && (m_en_clks % 5 != 0) && m_drop < 65535) begin
                    m_drop++;
                end
                m_tick = ((m_en_clks % PER) == PER - 1) || (m_tick && !m_acc);
                m_en_clks++;
            end
        end
    end

    bit mon_on = 0;

    task automatic check_all();
        chk("hlc_clock", 64'(hlc_clock), 64'(m_hlc_clock & en));
        chk("hlc_clock_cnt", 64'(hlc_clock_cnt), 64'(m_cnt));
        chk("hlc_a", 64'(hlc_a), 64'(m_a));
        chk("hlc_b", 64'(hlc_b), 64'(m_b));
        chk("hlc_id", 64'(hlc_id), 64'(m_id));
        chk("hlc_en", 64'({hlc_en_time_stream, hlc_en_a_impl_b, hlc_en_not_a,
                           hlc_en_neq, hlc_en_gt, hlc_en_lt}), 64'(m_sched));
        chk("llc_stage", 64'(llc_stage), 64'(m_en_clks % 5));
        chk("outputs", 64'({output_a_impl_b, output_not_a, output_neq, output_gt, output_lt}),
            64'({m_aib, m_not_a, m_neq, m_gt, m_lt}));
        chk("time_stream", 64'(output_time_stream), 64'(m_ts));
        chk("aktv", 64'({output_time_stream_aktv, output_a_impl_b_aktv, output_not_a_aktv,
                         output_neq_aktv, output_gt_aktv, output_lt_aktv}),
            64'(m_aktv & {6{en}}));
`ifdef BOOL_COMP_DROP_CNT_EN
        chk("dropped_cnt", 64'(dropped_cnt), 64'(m_drop));
`endif
    endtask

    always @(negedge clk) if (mon_on) check_all();

    // ---------------- directed vectors ----------------
    typedef struct {
        bit a, b; byte id; bit na, nb, nid;
        bit lt, gt, neq, not_a, aib; bit [4:0] aktv; longint cnt;
    } vec_t;
    vec_t tbl[6];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_stage(input int s);
        int g;
        g = 0;
        while ((m_en_clks % 5) != s && g < 20) begin
            step();
            g++;
        end
        if (g >= 20) chk("wait_stage_timeout", 64'(g), 64'(0));
    endtask

    function automatic logic [4:0] aktv5();
        return {output_a_impl_b_aktv, output_not_a_aktv, output_neq_aktv,
                output_gt_aktv, output_lt_aktv};
    endfunction

    initial begin
        bit  got;
        byte eb;

        //       a  b  id    na nb nid  lt gt neq na aib aktv      cnt
        tbl[0] = '{1, 1, 8'sd2,   1, 1, 1,  1, 0, 0, 0, 1, 5'b11111, 1};
        tbl[1] = '{1, 0, 8'sd3,   1, 1, 1,  0, 0, 1, 0, 0, 5'b11111, 2};
        tbl[2] = '{0, 0, 8'sd4,   1, 0, 1,  0, 1, 1, 1, 0, 5'b01011, 3};
        tbl[3] = '{0, 1, -8'sd128, 1, 1, 1, 1, 0, 1, 1, 1, 5'b11111, 4};
        tbl[4] = '{1, 0, 8'sd127, 0, 1, 0,  1, 0, 1, 1, 1, 5'b00000, 5};
        tbl[5] = '{1, 0, 8'sd127, 0, 0, 1,  0, 1, 1, 1, 1, 5'b00011, 6};

        #3 rst = 1'b0;
        #10;
        chk("rst_outputs", 64'({output_lt, output_gt, output_neq, output_not_a, output_a_impl_b}), 64'(0));
        chk("rst_ts", 64'(output_time_stream), 64'(0));
        chk("rst_cnt", 64'(hlc_clock_cnt), 64'(0));
        chk("rst_stage", 64'(llc_stage), 64'(0));
        chk("rst_hlc_id", 64'(hlc_id), 64'(0));
        @(negedge clk);
        #1;
        rst = 1'b1;
        en = 1'b1;
        mon_on = 1'b1;

        foreach (tbl[i]) begin
            wait_stage(0);
            input_a = tbl[i].a; input_b = tbl[i].b; input_id = tbl[i].id;
            new_input_a = tbl[i].na; new_input_b = tbl[i].nb; new_input_id = tbl[i].nid;
            step();
            chk($sformatf("vec%0d_hlc_clock", i), 64'(hlc_clock), 64'(1));
            chk($sformatf("vec%0d_cnt", i), 64'(hlc_clock_cnt), 64'(tbl[i].cnt));
            new_input_a = 0; new_input_b = 0; new_input_id = 0;
            repeat (4) step();
            chk($sformatf("vec%0d_vals", i),
                64'({output_lt, output_gt, output_neq, output_not_a, output_a_impl_b}),
                64'({tbl[i].lt, tbl[i].gt, tbl[i].neq, tbl[i].not_a, tbl[i].aib}));
            chk($sformatf("vec%0d_aktv", i), 64'(aktv5()), 64'(tbl[i].aktv));
            step();
            chk($sformatf("vec%0d_aktv_off", i), 64'(aktv5()), 64'(0));
        end

        // periodic stream: 1,2,...,127,-128
        for (int k = 1; k <= 128; k++) begin
            got = 0;
            for (int c = 0; c < 700 && !got; c++) begin
                step();
                if (output_time_stream_aktv) got = 1;
            end
            chk("ts_strobe_seen", 64'(got), 64'(1));
            eb = byte'(k);
            if (got) chk($sformatf("ts_value_%0d", k), 64'(output_time_stream), 64'(eb));
            if (k == 1) begin
                chk("ts_sched_only", 64'({hlc_en_time_stream, hlc_en_lt, hlc_en_gt, hlc_en_neq,
                                          hlc_en_not_a, hlc_en_a_impl_b}), 64'(6'b100000));
            end
        end

        // input raised mid-evaluation is dropped
        wait_stage(2);
        input_a = ~input_a;
        new_input_a = 1;
        step();
        new_input_a = 0;
        chk("drop_no_accept", 64'(hlc_clock), 64'(0));
        chk("drop_cnt_hold", 64'(hlc_clock_cnt), 64'(134));
`ifdef BOOL_COMP_DROP_CNT_EN
        chk("drop_counted", 64'(dropped_cnt), 64'(1));
`endif
        repeat (5) step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            input_a = 1'($urandom); input_b = 1'($urandom); input_id = 8'($urandom);
            new_input_a = ($urandom_range(0, 3) == 0);
            new_input_b = ($urandom_range(0, 3) == 0);
            new_input_id = ($urandom_range(0, 3) == 0);
            step();
        end
        en = 1; new_input_a = 0; new_input_b = 0; new_input_id = 0;
        repeat (5) step();

        // reset in the middle of an evaluation
        wait_stage(0);
        input_a = 1; input_b = 0; input_id = -8'sd5;
        new_input_a = 1; new_input_b = 1; new_input_id = 1;
        step();
        new_input_a = 0; new_input_b = 0; new_input_id = 0;
        step();
        chk("pre_rst_stage", 64'(llc_stage), 64'(2));
        rst = 1'b0;
        #1;
        chk("mid_rst_vals", 64'({output_lt, output_gt, output_neq, output_not_a, output_a_impl_b}), 64'(0));
        chk("mid_rst_ts", 64'(output_time_stream), 64'(0));
        chk("mid_rst_stage", 64'(llc_stage), 64'(0));
        chk("mid_rst_cnt", 64'(hlc_clock_cnt), 64'(0));
        chk("mid_rst_sched", 64'({hlc_en_lt, hlc_en_neq, hlc_en_not_a}), 64'(0));
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_no_aktv", 64'({output_time_stream_aktv, aktv5()}), 64'(0));
        end

        mon_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bool_comp_monitor.md
Name: bool_comp_monitor

Overview:
- Hardware stream monitor for a fixed specification with three input streams: a (bool), b (bool) and id (signed 8).
- Six outputs: lt, gt, neq, not_a, a_impl_b (event-driven) and time_stream (periodic).
- A high-level controller (HLC) latches input events and schedules streams. A 5-stage low-level controller (LLC) evaluates them, so the monitor accepts at most one event every 5 clocks.
- HLC/LLC state is exported on debug ports.

Parameters:
- PERIOD_CYCLES, 500: enabled clocks between time_stream evaluations.
- LT_BOUND, 3: lt := id < LT_BOUND (signed).
- GT_BOUND, 3: gt := id > GT_BOUND (signed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable.
- input_a / new_input_a  in  1/1  value a and its valid flag.
- input_b / new_input_b  in  1/1  value b and its valid flag.
- input_id / new_input_id  in  8 signed/1  value id and its valid flag.
- hlc_clock  out  1  one-cycle pulse when an event is accepted.
- hlc_clock_cnt  out  64 signed  count of accepted events.
- hlc_a, hlc_b, hlc_id  out  1/1/8 signed  latched input values.
- hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream  out  1 each  schedule of the current event.
- llc_stage  out  64 signed  LLC stage, 0..4.
- output_lt, output_gt, output_neq, output_not_a, output_a_impl_b  out  1 each  stream values.
- output_time_stream  out  8 signed  periodic stream value.
- output_*_aktv (one per output)  out  1 each  one-cycle "value updated" strobe.

Behaviour:
- Reset (rst=0, asynchronous): every register and output clears to 0, including stage, counters, pending tick, latched values and all stream values. An in-flight evaluation is discarded.
- en=0 freezes the following, and all *_aktv and hlc_clock read 0:
  - stage;
  - period counter;
  - event acceptance.
- Stage counter (when en=1): advances one step per clock, 0→1→2→3→4→0.
- Period counter: counts enabled clocks 0..PERIOD_CYCLES-1 and wraps. On wrap it sets tick_pending.
  - A second wrap before the tick is consumed is lost; tick_pending is a single flag.
- Acceptance happens on the edge where en=1, stage==0 and (any new_input_* =1 or tick_pending). On that edge:
  - Latch hlc_a, hlc_b and hlc_id only from flags that are set; the others keep their previous values.
  - hlc_en_lt = hlc_en_gt = new_input_id.
  - hlc_en_not_a = new_input_a.
  - hlc_en_neq = hlc_en_a_impl_b = new_input_a & new_input_b.
  - hlc_en_time_stream = tick_pending, which then clears. A tick and an input on the same edge are handled together.
  - Pulse hlc_clock for one cycle and increment hlc_clock_cnt (wraps).
- New-input flags raised while stage≠0 are ignored (the event is dropped).
- Evaluation is spread across stages 1..3 in any split. The edge taking stage 4→0 (4 clocks after acceptance) does the following:
  - Registers outputs for enabled streams only; disabled streams hold their value.
  - lt = hlc_id < LT_BOUND; gt = hlc_id > GT_BOUND.
  - not_a = ~hlc_a; neq = hlc_a ^ hlc_b; a_impl_b = ~hlc_a | hlc_b.
  - time_stream = previous time_stream + 1, 8-bit wrap (127→-128).
  - Each output_X_aktv = hlc_en_X for exactly one cycle.
- hlc_en_* hold until the next acceptance.

Optional Feature:
- Macro BOOL_COMP_DROP_CNT_EN.
- When defined: adds output port dropped_cnt (16 bits). It increments, saturating at 0xFFFF, on each enabled clock where any new_input_* =1 and stage≠0. It resets to 0.
- When undefined: the port and its logic are absent; drops are silent.

Test Plan:
- Reset then en=1. At stage 0 apply a=1, b=1, id=2 with all new flags set. Required: hlc_clock pulses; 4 clocks later lt=1, gt=0, neq=0, not_a=0, a_impl_b=1, and the five aktv strobes are each 1 for one cycle.
- At the next stage 0 apply a=1, b=0, id=3 with all flags. Required: lt=0, gt=0, neq=1, not_a=0, a_impl_b=0; hlc_clock_cnt=2.
- Apply a=0, id=4 with new_b=0. Required: gt=1, lt=0, not_a=1; neq stays 1 and a_impl_b stays 0, and their aktv strobes stay 0.
- Run PERIOD_CYCLES enabled clocks with no inputs. Required: an acceptance with only hlc_en_time_stream set; time_stream goes 0→1. Checks 127→-128 wrap after 128 periods.
- Raise new_input_a at stage 2. Required: no acceptance, outputs unchanged; dropped_cnt=1 when the macro is enabled.
- Assert rst=0 at stage 2 of an evaluation. Required: all outputs 0 immediately, no aktv strobe afterwards, llc_stage=0.
